// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline hold/flush sequencer for the 3-stage IF/ID/EX core
//
// Purpose:
//   Turns EX-stage events (taken jump, multi-cycle op, debug halt) into PC and
//   stage-register hold/flush strobes, and drives the PC redirect. The strobes
//   are Mealy outputs of the current state and this cycle's inputs. Only the
//   state, the multi-cycle wait counter and the sticky timeout flag are stored.
//
// Parameters:
//   ADDR_W   PC / jump target width
//   TIMEOUT  maximum MC_WAIT cycles before the pending EX op is abandoned (>=2)
//
// Ports:
//   sys_clk       in   core clock, rising edge
//   sys_rst       in   asynchronous, active-high reset
//   jump_req      in   EX: branch/jump taken this cycle
//   jump_addr     in   EX: jump target
//   mc_start      in   EX: multi-cycle op issued this cycle
//   mc_done       in   multi-cycle unit result valid this cycle
//   halt_req      in   debug halt request (level)
//   hold_pc       out  freeze PC
//   hold_if_id    out  freeze IF/ID register
//   hold_id_ex    out  freeze ID/EX register
//   flush_if_id   out  bubble into IF/ID (wins over hold)
//   flush_id_ex   out  bubble into ID/EX (wins over hold)
//   pc_load       out  PC <= pc_load_addr at next edge
//   pc_load_addr  out  redirect target, zero when pc_load is low
//   halted        out  core is in HALT
//   mc_timeout    out  sticky: a multi-cycle op was abandoned
//   state         out  0 RUN, 1 MC_WAIT, 2 HALT

module pipe_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              jump_req,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              mc_start,
  input  logic              mc_done,
  input  logic              halt_req,
  output logic              hold_pc,
  output logic              hold_if_id,
  output logic              hold_id_ex,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_load_addr,
  output logic              halted,
  output logic              mc_timeout,
  output logic [1:0]        state
);

  localparam logic [1:0] S_RUN     = 2'd0;
  localparam logic [1:0] S_MC_WAIT = 2'd1;
  localparam logic [1:0] S_HALT    = 2'd2;

  // Counter only has to reach TIMEOUT-1, where the abort fires, so it can
  // never wrap.
  localparam int             CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= S_RUN;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    timeout_d    = timeout_q;
    hold_pc      = 1'b0;
    hold_if_id   = 1'b0;
    hold_id_ex   = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    pc_load      = 1'b0;
    pc_load_addr = '0;

    case (state_q)
      S_MC_WAIT: begin
        // jump_req / mc_start cannot be genuine while EX is stalled.
        if (mc_done) begin
          // Result arrives: release everything this cycle. A halt raised
          // during the wait is taken now rather than dropped.
          state_d = halt_req ? S_HALT : S_RUN;
        end else if (cnt_q == CNT_LAST) begin
          // Give up on the op: keep fetch frozen one more cycle while EX
          // is overwritten with a bubble so the op never retires.
          hold_pc     = 1'b1;
          hold_if_id  = 1'b1;
          flush_id_ex = 1'b1;
          timeout_d   = 1'b1;
          state_d     = S_RUN;
        end else begin
          hold_pc    = 1'b1;
          hold_if_id = 1'b1;
          hold_id_ex = 1'b1;
          cnt_d      = cnt_q + CNT_W'(1);
        end
      end

      S_HALT: begin
        // EX is kept a bubble so the instruction that was there is not
        // executed twice; the IF/ID instruction resumes on exit.
        hold_pc     = 1'b1;
        hold_if_id  = 1'b1;
        flush_id_ex = 1'b1;
        if (!halt_req) begin
          state_d = S_RUN;
        end
      end

      default: begin
        // RUN, and the unused encoding which behaves as RUN for one cycle.
        if (jump_req) begin
          pc_load      = 1'b1;
          pc_load_addr = jump_addr;
          flush_if_id  = 1'b1;
          flush_id_ex  = 1'b1;
        end else if (mc_start) begin
          hold_pc    = 1'b1;
          hold_if_id = 1'b1;
          hold_id_ex = 1'b1;
          cnt_d      = '0;
          state_d    = S_MC_WAIT;
        end else if (halt_req) begin
          hold_pc     = 1'b1;
          hold_if_id  = 1'b1;
          flush_id_ex = 1'b1;
          state_d     = S_HALT;
        end
        if (state_q != S_RUN) begin
          state_d = S_RUN;
        end
      end
    endcase
  end

  assign halted     = (state_q == S_HALT);
  assign mc_timeout = timeout_q;
  assign state      = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

  localparam int AW = 32;
  localparam int TO = 8;

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic          jump_req;
  logic [AW-1:0] jump_addr;
  logic          mc_start;
  logic          mc_done;
  logic          halt_req;
  logic          hold_pc;
  logic          hold_if_id;
  logic          hold_id_ex;
  logic          flush_if_id;
  logic          flush_id_ex;
  logic          pc_load;
  logic [AW-1:0] pc_load_addr;
  logic          halted;
  logic          mc_timeout;
  logic [1:0]    state;

  int checks   = 0;
  int failures = 0;

  // Reference model: which mode the core is in, how long the current
  // multi-cycle op has been waited for, and whether an op was ever abandoned.
  localparam int M_RUN  = 0;
  localparam int M_WAIT = 1;
  localparam int M_HALT = 2;
  int m_mode   = M_RUN;
  int m_waited = 0;
  bit m_to     = 1'b0;

  pipe_ctrl #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .jump_req     (jump_req),
    .jump_addr    (jump_addr),
    .mc_start     (mc_start),
    .mc_done      (mc_done),
    .halt_req     (halt_req),
    .hold_pc      (hold_pc),
    .hold_if_id   (hold_if_id),
    .hold_id_ex   (hold_id_ex),
    .flush_if_id  (flush_if_id),
    .flush_id_ex  (flush_id_ex),
    .pc_load      (pc_load),
    .pc_load_addr (pc_load_addr),
    .halted       (halted),
    .mc_timeout   (mc_timeout),
    .state        (state)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] obs_vec();
    return {54'd0, hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex,
            pc_load, halted, mc_timeout, state};
  endfunction

  // One clock cycle: drive inputs, compare Mealy outputs with the model,
  // clock, advance the model. Entered and left at posedge + 1.
  task automatic step(input bit jr, input logic [AW-1:0] a, input bit ms, input bit md,
                      input bit hr, input string tag);
    bit hp = 0, hi = 0, he = 0, fi = 0, fe = 0, pl = 0;
    int nmode = m_mode;
    int nwait = m_waited;
    bit nto   = m_to;
    jump_req  = jr;
    jump_addr = a;
    mc_start  = ms;
    mc_done   = md;
    halt_req  = hr;
    #2;
    if (m_mode == M_HALT) begin
      hp = 1; hi = 1; fe = 1;
      nmode = hr ? M_HALT : M_RUN;
    end else if (m_mode == M_WAIT) begin
      if (md) begin
        nmode = hr ? M_HALT : M_RUN;
      end else if (m_waited == TO - 1) begin
        hp = 1; hi = 1; fe = 1; nto = 1; nmode = M_RUN;
      end else begin
        hp = 1; hi = 1; he = 1; nwait = m_waited + 1;
      end
    end else begin
      if (jr) begin
        pl = 1; fi = 1; fe = 1;
      end else if (ms) begin
        hp = 1; hi = 1; he = 1; nmode = M_WAIT; nwait = 0;
      end else if (hr) begin
        hp = 1; hi = 1; fe = 1; nmode = M_HALT;
      end
    end
    check({tag, "_strobes"}, obs_vec(),
          {54'd0, hp, hi, he, fi, fe, pl, (m_mode == M_HALT), m_to, 2'(m_mode)});
    check({tag, "_addr"}, 64'(pc_load_addr), pl ? 64'(a) : 64'd0);
    @(posedge sys_clk);
    #1;
    m_mode   = nmode;
    m_waited = nwait;
    m_to     = nto;
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(0, '0, 0, 0, 0, tag);
  endtask

  // Asynchronous reset in mid-cycle; outputs must clear with no clock edge.
  task automatic do_reset(input string tag);
    jump_req = 0; jump_addr = '0; mc_start = 0; mc_done = 0; halt_req = 0;
    sys_rst = 1'b1;
    #1;
    check({tag, "_rst_strobes"}, obs_vec(), 64'd0);
    check({tag, "_rst_addr"}, 64'(pc_load_addr), 64'd0);
    m_mode = M_RUN; m_waited = 0; m_to = 1'b0;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    sys_rst = 1'b1;
    jump_req = 0; jump_addr = '0; mc_start = 0; mc_done = 0; halt_req = 0;
    #3;
    check("por_strobes", obs_vec(), 64'd0);
    check("por_addr", 64'(pc_load_addr), 64'd0);
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    @(posedge sys_clk);
    #1;

    // Jump redirect.
    step(1, 32'h40, 0, 0, 0, "jump");
    check("jump_state", 64'(state), 64'd0);
    idle(1, "jump_after");

    // Multi-cycle op completing after five cycles.
    step(0, '0, 1, 0, 0, "mc_start");
    check("mc_state_n1", 64'(state), 64'd1);
    idle(4, "mc_wait");
    step(0, '0, 0, 1, 0, "mc_done");
    check("mc_state_done", 64'(state), 64'd0);

    // Timeout abort and sticky flag.
    step(0, '0, 1, 0, 0, "to_start");
    idle(TO, "to_wait");
    check("to_state", 64'(state), 64'd0);
    check("to_flag", 64'(mc_timeout), 64'd1);
    idle(2, "to_after");
    check("to_sticky", 64'(mc_timeout), 64'd1);

    // Reset in MC_WAIT with cnt=5 clears state and the sticky flag.
    step(0, '0, 1, 0, 0, "r_start");
    idle(5, "r_wait");
    check("r_pre_state", 64'(state), 64'd1);
    do_reset("r");

    // Halt raised during MC_WAIT is deferred until mc_done.
    step(0, '0, 1, 0, 0, "dh_start");
    step(0, '0, 0, 0, 1, "dh_w0");
    step(0, '0, 0, 0, 1, "dh_w1");
    step(0, '0, 0, 1, 1, "dh_done");
    check("dh_state_halt", 64'(state), 64'd2);
    check("dh_halted", 64'(halted), 64'd1);
    step(0, '0, 0, 0, 1, "dh_halt");
    step(0, '0, 0, 0, 0, "dh_release");
    check("dh_state_run", 64'(state), 64'd0);
    idle(1, "dh_after");

    // Jump wins over mc_start and halt_req; halt taken next cycle.
    step(1, 32'h100, 1, 0, 1, "col");
    check("col_state", 64'(state), 64'd0);
    step(0, '0, 0, 0, 1, "col_halt");
    check("col_state_halt", 64'(state), 64'd2);
    step(0, '0, 0, 0, 0, "col_release");
    check("col_state_run", 64'(state), 64'd0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        do_reset("rnd");
      end else begin
        step($urandom_range(0, 7) == 0, $urandom, $urandom_range(0, 5) == 0,
             $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0, "rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
